// File: rtl/niosdramproc_joseproc3_div_pkg.sv
// Shared definitions for the joseproc3 iterative divider cell:
// state encoding, counter width and the divide-by-zero quotient.
package niosdramproc_joseproc3_div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_ST_IDLE = 2'd0;
    localparam div_state_t DIV_ST_PREP = 2'd1;
    localparam div_state_t DIV_ST_ITER = 2'd2;
    localparam div_state_t DIV_ST_FIX  = 2'd3;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_DATA_W-1:0] DIV_ZERO_Q = {DIV_DATA_W{1'b1}};

endpackage

// File: rtl/niosdramproc_joseproc3_div_step.sv
// One radix-2 restoring division step. The next dividend bit (top of q)
// shifts into the partial remainder, and the divisor is trial-subtracted.
// Because the partial remainder is always below the divisor, a
// DATA_W+1-bit difference is wide enough: its top bit is the borrow.
module niosdramproc_joseproc3_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] r_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] r_next_o,
    output logic [DATA_W-1:0] q_next_o
);

    logic [DATA_W:0] shifted_s;
    logic [DATA_W:0] diff_s;
    logic            borrow_s;

    // Trial subtract, then keep the difference or restore the shifted remainder.
    always_comb begin
        shifted_s = {r_i, q_i[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, d_i};
        borrow_s  = diff_s[DATA_W];
        if (borrow_s) begin
            r_next_o = shifted_s[DATA_W-1:0];
        end else begin
            r_next_o = diff_s[DATA_W-1:0];
        end
        q_next_o = {q_i[DATA_W-2:0], ~borrow_s};
    end

endmodule

// File: rtl/niosdramproc_joseproc3_div_cell.sv
// Iterative radix-2 restoring divider for div/divu in the joseproc3 A stage.
// Sequence: IDLE -> PREP (magnitudes, sign flags) -> ITER (DATA_W steps)
// -> FIX (done pulse). The sign fix-up is applied on the edge that enters
// FIX, so quotient/remainder are registered and valid in the done cycle.
module niosdramproc_joseproc3_div_cell
    import niosdramproc_joseproc3_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quotient,
    output logic [DATA_W-1:0] A_div_remainder
);

    localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]    DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_CNT_W-1:0] CNT_ZERO  = {DIV_CNT_W{1'b0}};
    localparam logic [DIV_CNT_W-1:0] CNT_ONE   = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_CNT_W-1:0] CNT_LOAD  = DIV_CNT_W'(DATA_W - 1);

    // Two's complement negation; |0x8000_0000| stays 0x8000_0000 as unsigned.
    function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
        return (~v) + DATA_ONE;
    endfunction

    div_state_t            state_q, state_d;
    logic                  signed_q, signed_d;
    logic [DATA_W-1:0]     src1_q, src1_d;
    logic [DATA_W-1:0]     src2_q, src2_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  neg_q_q, neg_q_d;
    logic                  neg_r_q, neg_r_d;
    logic                  dz_q, dz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_W-1:0]     quotient_q, quotient_d;
    logic [DATA_W-1:0]     remainder_q, remainder_d;
    logic [DATA_W-1:0]     step_r_s, step_q_s;

    niosdramproc_joseproc3_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .r_i      (rem_q),
        .q_i      (quo_q),
        .d_i      (dvs_q),
        .r_next_o (step_r_s),
        .q_next_o (step_q_s)
    );

    // State and datapath registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DIV_ST_IDLE;
            signed_q    <= 1'b0;
            src1_q      <= DATA_ZERO;
            src2_q      <= DATA_ZERO;
            rem_q       <= DATA_ZERO;
            quo_q       <= DATA_ZERO;
            dvs_q       <= DATA_ZERO;
            cnt_q       <= CNT_ZERO;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= DATA_ZERO;
            remainder_q <= DATA_ZERO;
        end else begin
            state_q     <= state_d;
            signed_q    <= signed_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Next-state: starts are only taken in IDLE, so a busy cell ignores them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_ST_IDLE: begin
                if (A_div_start) begin
                    state_d = DIV_ST_PREP;
                end else begin
                    state_d = DIV_ST_IDLE;
                end
            end
            DIV_ST_PREP: state_d = DIV_ST_ITER;
            DIV_ST_ITER: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DIV_ST_FIX;
                end else begin
                    state_d = DIV_ST_ITER;
                end
            end
            DIV_ST_FIX:  state_d = DIV_ST_IDLE;
            default:     state_d = DIV_ST_IDLE;
        endcase
    end

    // Datapath and output updates per state.
    always_comb begin
        signed_d    = signed_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            DIV_ST_IDLE: begin
                if (A_div_start) begin
                    signed_d = A_div_signed;
                    src1_d   = A_div_src1;
                    src2_d   = A_div_src2;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            DIV_ST_PREP: begin
                quo_d   = (signed_q && src1_q[DATA_W-1]) ? neg2(src1_q) : src1_q;
                dvs_d   = (signed_q && src2_q[DATA_W-1]) ? neg2(src2_q) : src2_q;
                neg_q_d = signed_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
                neg_r_d = signed_q & src1_q[DATA_W-1];
                dz_d    = (src2_q == DATA_ZERO);
                rem_d   = DATA_ZERO;
                cnt_d   = CNT_LOAD;
            end
            DIV_ST_ITER: begin
                rem_d = step_r_s;
                quo_d = step_q_s;
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Last step: fix signs now so results register with done.
                    done_d = 1'b1;
                    if (dz_q) begin
                        quotient_d  = DIV_ZERO_Q[DATA_W-1:0];
                        remainder_d = src1_q;
                    end else begin
                        quotient_d  = neg_q_q ? neg2(step_q_s) : step_q_s;
                        remainder_d = neg_r_q ? neg2(step_r_s) : step_r_s;
                    end
                end
            end
            DIV_ST_FIX: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign A_div_busy      = busy_q;
    assign A_div_done      = done_q;
    assign A_div_quotient  = quotient_q;
    assign A_div_remainder = remainder_q;

endmodule

// File: tb/tb_niosdramproc_joseproc3_div_cell.sv
// Directed bench for the joseproc3 divider cell: a vector table of
// operations plus hand-written collision and mid-operation reset sequences.
module tb_niosdramproc_joseproc3_div_cell;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;

    int pass_cnt;
    int total_cnt;

    niosdramproc_joseproc3_div_cell dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .A_div_start     (start),
        .A_div_signed    (sgn),
        .A_div_src1      (src1),
        .A_div_src2      (src2),
        .A_div_busy      (busy),
        .A_div_done      (done),
        .A_div_quotient  (quo),
        .A_div_remainder (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one start, then watch a fixed window of cycles after it.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        start = 1'b1; sgn = s; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0; sgn = ~s; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
        lat = 0; busy_n = 0; done_n = 0; q = 32'h0; r = 32'h0;
        for (int k = 1; k <= 45; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) begin
                    lat = k; q = quo; r = rem;
                end
            end
        end
    endtask

    vec_t        vecs[10];
    logic [31:0] q_v, r_v;
    int          lat_v, busy_v, done_v;

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset_n = 1'b0; start = 1'b0; sgn = 1'b0; src1 = 32'h0; src2 = 32'h0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[5] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[6] = '{1'b1, 32'h8765_4321,  32'd0,          32'hFFFF_FFFF,  32'h8765_4321};
        vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[9] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quo", quo, 32'd0);
        chk("reset_rem", rem, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, q_v, r_v, lat_v, busy_v, done_v);
            chk($sformatf("vec%0d_quo", i), q_v, vecs[i].eq);
            chk($sformatf("vec%0d_rem", i), r_v, vecs[i].er);
            chk($sformatf("vec%0d_latency", i), 32'(lat_v), 32'd34);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_v), 32'd34);
            chk($sformatf("vec%0d_done_pulses", i), 32'(done_v), 32'd1);
        end

        // Collision: 9/4 in flight, 50/5 offered at cycle 10 and in the done cycle.
        begin
            int dn, lat, bsy_after;
            logic [31:0] qd, rd;
            dn = 0; lat = 0; bsy_after = 0; qd = 32'h0; rd = 32'h0;
            @(negedge clk);
            start = 1'b1; sgn = 1'b0; src1 = 32'd9; src2 = 32'd4;
            for (int k = 1; k <= 80; k++) begin
                @(negedge clk);
                if (done) begin
                    dn++;
                    if (lat == 0) begin
                        lat = k; qd = quo; rd = rem;
                    end
                end
                if (k > 34 && busy) bsy_after++;
                if ((k == 10) || (done && dn == 1 && lat == k)) begin
                    start = 1'b1; src1 = 32'd50; src2 = 32'd5;
                end else begin
                    start = 1'b0;
                end
            end
            chk("coll_quo", qd, 32'd2);
            chk("coll_rem", rd, 32'd1);
            chk("coll_latency", 32'(lat), 32'd34);
            chk("coll_done_pulses", 32'(dn), 32'd1);
            chk("coll_busy_after", 32'(bsy_after), 32'd0);
            chk("coll_hold_quo", quo, 32'd2);
            chk("coll_hold_rem", rem, 32'd1);
        end

        // Reset during ITER cycle 15 of a 100/7 divide.
        begin
            int dn;
            dn = 0;
            @(negedge clk);
            start = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) dn++;
            end
            reset_n = 1'b0;
            #1;
            chk("rst_mid_busy", {31'd0, busy}, 32'd0);
            chk("rst_mid_done", {31'd0, done}, 32'd0);
            chk("rst_mid_quo", quo, 32'd0);
            chk("rst_mid_rem", rem, 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("rst_mid_no_done", 32'(dn), 32'd0);
            run_op(1'b0, 32'hFFFF_FFFF, 32'd1, q_v, r_v, lat_v, busy_v, done_v);
            chk("rst_after_quo", q_v, 32'hFFFF_FFFF);
            chk("rst_after_rem", r_v, 32'd0);
            chk("rst_after_latency", 32'(lat_v), 32'd34);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
